// File: rtl/riscv_mem_responder_pkg.sv
// Message layouts and byte-lane helpers shared by the memory responder and its response queue.
// Request {type,addr,len,data} is 67b, response {type,len,data} is 35b; len 0 encodes 4 bytes.
package riscv_mem_responder_pkg;
  localparam int REQ_W  = 67;
  localparam int RESP_W = 35;

  typedef enum logic {MEM_READ = 1'b0, MEM_WRITE = 1'b1} mem_type_e;

  typedef struct packed {
    mem_type_e   typ;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_t;

  typedef struct packed {
    mem_type_e   typ;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_t;

  // Shifting by the offset truncates lanes past byte 3, which drops any spill into the next word.
  function automatic logic [3:0] lane_mask(input logic [1:0] off, input logic [1:0] len);
    logic [3:0] base;
    case (len)
      2'd1:    base = 4'b0001;
      2'd2:    base = 4'b0011;
      2'd3:    base = 4'b0111;
      default: base = 4'b1111;
    endcase
    return base << off;
  endfunction

  function automatic logic [31:0] byte_mask(input logic [1:0] len);
    logic [31:0] m;
    case (len)
      2'd1:    m = 32'h0000_00ff;
      2'd2:    m = 32'h0000_ffff;
      2'd3:    m = 32'h00ff_ffff;
      default: m = 32'hffff_ffff;
    endcase
    return m;
  endfunction
endpackage

// File: rtl/riscv_mem_resp_queue.sv
// In-order response FIFO, DEPTH x 35b circular buffer; an entry is visible the cycle after enqueue (no bypass).
// enq_rdy deasserts when full; deq_vld is the non-empty flag and deq_dat holds until dequeued.
module riscv_mem_resp_queue
  import riscv_mem_responder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      enq_vld,
  output logic      enq_rdy,
  input  mem_resp_t enq_dat,
  output logic      deq_vld,
  input  logic      deq_rdy,
  output mem_resp_t deq_dat
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = 1;

  mem_resp_t      slots [DEPTH];
  logic [PTR_W:0] wptr;
  logic [PTR_W:0] rptr;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign deq_vld = (wptr != rptr);
  assign enq_rdy = !((wptr[PTR_W] != rptr[PTR_W]) && (wptr[PTR_W-1:0] == rptr[PTR_W-1:0]));
  assign deq_dat = slots[rptr[PTR_W-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (enq_vld && enq_rdy) wptr <= wptr + PTR_ONE;
      if (deq_vld && deq_rdy) rptr <= rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (enq_vld && enq_rdy) slots[wptr[PTR_W-1:0]] <= enq_dat;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) enq_vld |-> enq_rdy);
endmodule

// File: rtl/riscv_mem_responder.sv
// Memory endpoint: word storage, byte-lane align, LATENCY-1 stage pipe, in-order queue; credits bound in-flight requests.
// RISCV_MEM_RESPONDER_RANDOM_DELAY_EN adds an LFSR-driven 0..7 cycle hold on each new queue head.
module riscv_mem_responder
  import riscv_mem_responder_pkg::*;
#(
  parameter int         NUM_WORDS        = 256,
  parameter int         LATENCY          = 2,
  parameter int         RESP_QUEUE_DEPTH = 4,
  parameter logic [7:0] LFSR_SEED        = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REQ_W-1:0]  memreq_msg,
  input  logic              memreq_val,
  output logic              memreq_rdy,
  output logic [RESP_W-1:0] memresp_msg,
  output logic              memresp_val,
  input  logic              memresp_rdy
);
  localparam int IDX_W = $clog2(NUM_WORDS);
  localparam int CNT_W = $clog2(RESP_QUEUE_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  mem_req_t         req;
  mem_resp_t        new_resp;
  mem_resp_t        enq_dat;
  mem_resp_t        deq_dat;
  logic [31:0]      words [NUM_WORDS];
  logic [IDX_W-1:0] idx;
  logic [1:0]       off;
  logic [31:0]      rd_word;
  logic [31:0]      wr_data;
  logic [3:0]       wr_lanes;
  logic             acc;
  logic             resp_hs;
  logic             enq_vld;
  logic             enq_rdy;
  logic             deq_vld;
  logic             deq_rdy;
  logic             hold_ok;
  logic [CNT_W-1:0] inflight_cnt;
  logic             unused_bits;

  assign req      = memreq_msg;
  assign idx      = req.addr[IDX_W+1:2];
  assign off      = req.addr[1:0];
  assign rd_word  = words[idx];
  assign wr_data  = req.data << {off, 3'b000};
  assign wr_lanes = lane_mask(off, req.len);

  assign memreq_rdy = (inflight_cnt < CNT_W'(RESP_QUEUE_DEPTH));
  assign acc        = memreq_val && memreq_rdy;
  assign resp_hs    = memresp_val && memresp_rdy;

  // Storage is deliberately left out of reset so contents survive a mid-run reset.
  always_ff @(posedge clk) begin
    if (acc && req.typ == MEM_WRITE) begin
      for (int k = 0; k < 4; k++) begin
        if (wr_lanes[k]) words[idx][8*k +: 8] <= wr_data[8*k +: 8];
      end
    end
  end

  always_comb begin
    new_resp     = '0;
    new_resp.typ = req.typ;
    new_resp.len = req.len;
    if (req.typ == MEM_READ) new_resp.data = (rd_word >> {off, 3'b000}) & byte_mask(req.len);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight_cnt <= '0;
    end else if (acc && !resp_hs) begin
      inflight_cnt <= inflight_cnt + CNT_ONE;
    end else if (!acc && resp_hs) begin
      inflight_cnt <= inflight_cnt - CNT_ONE;
    end
  end

  // Stages never stall: the credit counter already reserved a queue slot for every accepted request.
  if (LATENCY == 1) begin : g_nopipe
    assign enq_vld = acc;
    assign enq_dat = new_resp;
  end else begin : g_pipe
    logic [LATENCY-2:0] stg_vld;
    mem_resp_t          stg_dat [LATENCY-1];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        stg_vld <= '0;
        for (int i = 0; i < LATENCY - 1; i++) stg_dat[i] <= '0;
      end else begin
        stg_vld[0] <= acc;
        stg_dat[0] <= new_resp;
        for (int i = 1; i < LATENCY - 1; i++) begin
          stg_vld[i] <= stg_vld[i-1];
          stg_dat[i] <= stg_dat[i-1];
        end
      end
    end

    assign enq_vld = stg_vld[LATENCY-2];
    assign enq_dat = stg_dat[LATENCY-2];
  end

  riscv_mem_resp_queue #(.DEPTH(RESP_QUEUE_DEPTH)) u_resp_queue (
    .clk     (clk),
    .rst_n   (reset),
    .enq_vld (enq_vld),
    .enq_rdy (enq_rdy),
    .enq_dat (enq_dat),
    .deq_vld (deq_vld),
    .deq_rdy (deq_rdy),
    .deq_dat (deq_dat)
  );

`ifdef RISCV_MEM_RESPONDER_RANDOM_DELAY_EN
  logic [7:0] lfsr;
  logic [2:0] hold_cnt;
  logic [2:0] eff_cnt;
  logic       head_armed;

  // A fresh head takes its hold straight from the LFSR, so a zero draw presents it the cycle it arrives.
  assign eff_cnt = head_armed ? hold_cnt : lfsr[2:0];
  assign hold_ok = (eff_cnt == 3'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr       <= LFSR_SEED;
      hold_cnt   <= '0;
      head_armed <= 1'b0;
    end else begin
      lfsr <= {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
      if (!deq_vld || resp_hs) begin
        head_armed <= 1'b0;
      end else begin
        head_armed <= 1'b1;
        hold_cnt   <= hold_ok ? 3'd0 : eff_cnt - 3'd1;
      end
    end
  end

  assign unused_bits = ^{req.addr[31:IDX_W+2], enq_rdy};
`else
  assign hold_ok     = 1'b1;
  assign unused_bits = ^{req.addr[31:IDX_W+2], enq_rdy, LFSR_SEED};
`endif

  assign memresp_val = deq_vld && hold_ok;
  assign deq_rdy     = memresp_rdy && hold_ok;
  assign memresp_msg = memresp_val ? deq_dat : '0;
endmodule
